// File: rtl/branch_ctrl_pkg.sv
// rtl/branch_ctrl_pkg.sv - shared FSM state type and RAS depth default for the branch redirect controller
package branch_ctrl_pkg;

   localparam int RAS_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_FLUSH = 2'd2
   } redir_state_t;

endpackage

// File: rtl/branch_ras.sv
// rtl/branch_ras.sv - circular return-address stack; oldest entry is overwritten when full
module branch_ras #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] din,
   output logic [31:0] top,
   output logic        valid
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] sp;
   logic [PW-1:0] sp_inc;
   logic [PW-1:0] sp_dec;
   logic [CW-1:0] cnt;

   assign sp_inc = sp + 1'b1;
   assign sp_dec = sp - 1'b1;
   assign valid  = (cnt != '0);
   assign top    = valid ? mem[sp] : 32'h0;

   // Stack pointer tracks the top slot; pointer wraps so a push when full lands on the oldest entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp  <= '0;
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      end else if (push && pop) begin
         mem[sp] <= din;
         if (cnt == '0) cnt <= CW'(1);
      end else if (push) begin
         mem[sp_inc] <= din;
         sp          <= sp_inc;
         if (cnt != FULL) cnt <= cnt + 1'b1;
      end else if (pop && cnt != '0) begin
         sp  <= sp_dec;
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - decode-stage redirect FSM with optional return-address stack (BRANCH_RAS_EN)
module branch_redirect_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        Rst,
   input  logic        dec_valid,
   input  logic        dec_jal,
   input  logic        dec_jalr,
   input  logic        dec_branch,
   input  logic        dec_comp,
   input  logic [31:0] dec_pc,
   input  logic [31:0] branoff,
   input  logic        br_taken,
   input  logic        rd_link,
   input  logic        rs1_link,
   input  logic        fetch_ready,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic        stall_dec,
   output logic [31:0] redirect_cnt,
   output logic        ras_valid,
   output logic [31:0] ras_top
);

   redir_state_t state, state_nx;
   logic         take;
   logic         start;
   logic         accept;
   logic [31:0]  target;

   assign take   = dec_valid & (dec_jal | dec_jalr | (dec_branch & br_taken));
   assign target = dec_jalr ? {branoff[31:1], 1'b0} : (dec_pc + branoff);

   // Next-state and request/flush/stall decode; decode inputs only matter in IDLE
   always_comb begin
      state_nx       = state;
      redirect_valid = 1'b0;
      flush          = 1'b0;
      stall_dec      = 1'b0;
      start          = 1'b0;
      accept         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (take) begin
               start    = 1'b1;
               state_nx = ST_REQ;
            end
         end
         ST_REQ: begin
            redirect_valid = 1'b1;
            stall_dec      = 1'b1;
            if (fetch_ready) begin
               accept   = 1'b1;
               state_nx = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            flush     = 1'b1;
            stall_dec = 1'b1;
            state_nx  = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Capture the target when a redirect starts; held stable through REQ
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst)        redirect_pc <= 32'h0;
      else if (start) redirect_pc <= target;
   end

   // Saturating count of redirects accepted by fetch
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst)                                    redirect_cnt <= 32'h0;
      else if (accept && redirect_cnt != '1)      redirect_cnt <= redirect_cnt + 32'd1;
   end

`ifdef BRANCH_RAS_EN
   logic [31:0] link;
   logic        ras_push;
   logic        ras_pop;

   assign link     = dec_pc + (dec_comp ? 32'd2 : 32'd4);
   assign ras_push = start & (dec_jal | dec_jalr) & rd_link;
   assign ras_pop  = start & dec_jalr & rs1_link;

   branch_ras #(
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst   (Rst),
      .push  (ras_push),
      .pop   (ras_pop),
      .din   (link),
      .top   (ras_top),
      .valid (ras_valid)
   );
`else
   logic unused_ras;
   assign unused_ras = ^{rd_link, rs1_link, dec_comp};
   assign ras_valid  = 1'b0;
   assign ras_top    = 32'h0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - table-driven bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        Rst;
   logic        dec_valid, dec_jal, dec_jalr, dec_branch, dec_comp;
   logic [31:0] dec_pc, branoff;
   logic        br_taken, rd_link, rs1_link, fetch_ready;
   logic        redirect_valid, flush, stall_dec, ras_valid;
   logic [31:0] redirect_pc, redirect_cnt, ras_top;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_cnt = 32'h0;

   always #5 clk = ~clk;

   branch_redirect_ctrl #(.RAS_DEPTH(4)) dut (
      .clk            (clk),
      .Rst            (Rst),
      .dec_valid      (dec_valid),
      .dec_jal        (dec_jal),
      .dec_jalr       (dec_jalr),
      .dec_branch     (dec_branch),
      .dec_comp       (dec_comp),
      .dec_pc         (dec_pc),
      .branoff        (branoff),
      .br_taken       (br_taken),
      .rd_link        (rd_link),
      .rs1_link       (rs1_link),
      .fetch_ready    (fetch_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .stall_dec      (stall_dec),
      .redirect_cnt   (redirect_cnt),
      .ras_valid      (ras_valid),
      .ras_top        (ras_top)
   );

   typedef struct {
      logic        v, jal, jalr, br, tk;
      logic [31:0] pc, off;
      logic        exp_go;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      dec_valid = 0; dec_jal = 0; dec_jalr = 0; dec_branch = 0; dec_comp = 0;
      br_taken = 0; rd_link = 0; rs1_link = 0;
      dec_pc = 32'h0; branoff = 32'h0;
   endtask

   // Full accepted redirect: decode cycle, REQ (fetch ready), FLUSH, back to IDLE
   task automatic xfer(input logic jal, input logic jalr, input logic comp,
                       input logic rdl, input logic rs1l,
                       input logic [31:0] pc, input logic [31:0] off);
      dec_valid = 1; dec_jal = jal; dec_jalr = jalr; dec_branch = 0; dec_comp = comp;
      rd_link = rdl; rs1_link = rs1l; dec_pc = pc; branoff = off; fetch_ready = 1;
      step();
      idle_inputs();
      step();
      step();
      exp_cnt++;
   endtask

   initial begin
      vecs[0] = '{1, 1, 0, 0, 0, 32'h0000_0100, 32'h0000_0020, 1, 32'h0000_0120};
      vecs[1] = '{1, 0, 0, 1, 0, 32'h0000_0010, 32'hFFFF_FFF0, 0, 32'h0};
      vecs[2] = '{1, 0, 0, 1, 1, 32'h0000_0010, 32'hFFFF_FFF0, 1, 32'h0000_0000};
      vecs[3] = '{1, 0, 1, 0, 0, 32'h0000_0040, 32'h0000_2001, 1, 32'h0000_2000};
      vecs[4] = '{1, 0, 0, 0, 0, 32'h0000_0080, 32'h0000_0008, 0, 32'h0};
      vecs[5] = '{1, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0008, 1, 32'h0000_0004};
      vecs[6] = '{1, 0, 1, 0, 0, 32'h0000_1000, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEE};
      vecs[7] = '{0, 1, 0, 0, 0, 32'h0000_0300, 32'h0000_0040, 0, 32'h0};

      idle_inputs();
      fetch_ready = 1;
      Rst = 1;
      #12;
      chk("rst_redirect_valid", 32'(redirect_valid), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_stall", 32'(stall_dec), 32'h0);
      chk("rst_pc", redirect_pc, 32'h0);
      chk("rst_cnt", redirect_cnt, 32'h0);
      chk("rst_ras_valid", 32'(ras_valid), 32'h0);
      chk("rst_ras_top", ras_top, 32'h0);
      Rst = 0;
      step();

      for (int i = 0; i < 8; i++) begin
         dec_valid = vecs[i].v; dec_jal = vecs[i].jal; dec_jalr = vecs[i].jalr;
         dec_branch = vecs[i].br; br_taken = vecs[i].tk;
         dec_pc = vecs[i].pc; branoff = vecs[i].off; fetch_ready = 1;
         step();
         idle_inputs();
         chk($sformatf("v%0d_redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].exp_go));
         chk($sformatf("v%0d_stall_n1", i), 32'(stall_dec), 32'(vecs[i].exp_go));
         if (vecs[i].exp_go) chk($sformatf("v%0d_pc", i), redirect_pc, vecs[i].exp_pc);
         step();
         chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].exp_go));
         if (vecs[i].exp_go) exp_cnt++;
         chk($sformatf("v%0d_cnt", i), redirect_cnt, exp_cnt);
         step();
         chk($sformatf("v%0d_idle_stall", i), 32'(stall_dec), 32'h0);
         chk($sformatf("v%0d_idle_flush", i), 32'(flush), 32'h0);
      end

      // JALR held in REQ for three cycles while fetch is busy; decode activity must be ignored
      fetch_ready = 0;
      dec_valid = 1; dec_jalr = 1; dec_pc = 32'h500; branoff = 32'h2001;
      step();
      dec_jalr = 0; dec_jal = 1; dec_pc = 32'h700; branoff = 32'h10;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("hold%0d_valid", k), 32'(redirect_valid), 32'h1);
         chk($sformatf("hold%0d_stall", k), 32'(stall_dec), 32'h1);
         chk($sformatf("hold%0d_pc", k), redirect_pc, 32'h2000);
         chk($sformatf("hold%0d_flush", k), 32'(flush), 32'h0);
         if (k < 2) step();
      end
      idle_inputs();
      fetch_ready = 1;
      step();
      exp_cnt++;
      chk("hold_flush", 32'(flush), 32'h1);
      chk("hold_cnt", redirect_cnt, exp_cnt);
      step();
      chk("hold_idle_valid", 32'(redirect_valid), 32'h0);
      chk("hold_idle_stall", 32'(stall_dec), 32'h0);

      // Reset pulse while in REQ aborts with no flush and no count increment
      fetch_ready = 0;
      dec_valid = 1; dec_jal = 1; dec_pc = 32'h40; branoff = 32'h8;
      step();
      idle_inputs();
      chk("abort_in_req", 32'(redirect_valid), 32'h1);
      Rst = 1;
      #2;
      chk("abort_async_valid", 32'(redirect_valid), 32'h0);
      Rst = 0;
      fetch_ready = 1;
      exp_cnt = 32'h0;
      step();
      chk("abort_flush", 32'(flush), 32'h0);
      chk("abort_valid", 32'(redirect_valid), 32'h0);
      chk("abort_cnt", redirect_cnt, exp_cnt);
      step();
      chk("abort_flush2", 32'(flush), 32'h0);
      chk("abort_cnt2", redirect_cnt, exp_cnt);

      // Return-address stack: five calls into a four-entry stack, then four returns
      for (int k = 0; k < 5; k++) xfer(1, 0, 0, 1, 0, 32'(k * 16), 32'h100);
`ifdef BRANCH_RAS_EN
      chk("ras_push_top", ras_top, 32'h44);
      chk("ras_push_valid", 32'(ras_valid), 32'h1);
`else
      chk("noras_valid", 32'(ras_valid), 32'h0);
      chk("noras_top", ras_top, 32'h0);
`endif
      xfer(0, 1, 0, 0, 1, 32'h900, 32'h44);
`ifdef BRANCH_RAS_EN
      chk("ras_pop1", ras_top, 32'h34);
`endif
      xfer(0, 1, 0, 0, 1, 32'h900, 32'h34);
`ifdef BRANCH_RAS_EN
      chk("ras_pop2", ras_top, 32'h24);
`endif
      xfer(0, 1, 0, 0, 1, 32'h900, 32'h24);
`ifdef BRANCH_RAS_EN
      chk("ras_pop3", ras_top, 32'h14);
`endif
      xfer(0, 1, 0, 0, 1, 32'h900, 32'h14);
      chk("ras_pop4_valid", 32'(ras_valid), 32'h0);
      chk("ras_cnt", redirect_cnt, exp_cnt);

      // Compressed call pushes pc+2; replace-top on JALR with both link bits
      xfer(1, 0, 1, 1, 0, 32'h200, 32'h40);
`ifdef BRANCH_RAS_EN
      chk("ras_comp_top", ras_top, 32'h202);
      chk("ras_comp_valid", 32'(ras_valid), 32'h1);
`else
      chk("noras_comp_valid", 32'(ras_valid), 32'h0);
`endif
      xfer(0, 1, 0, 1, 1, 32'h600, 32'h202);
`ifdef BRANCH_RAS_EN
      chk("ras_replace_top", ras_top, 32'h604);
`else
      chk("noras_replace_top", ras_top, 32'h0);
`endif
      chk("final_cnt", redirect_cnt, exp_cnt);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 Parameter RAS_DEPTH, default 4, number of return-address-stack entries; power of two, 2..16.
REQ-002 clk  in  1  core clock; all state updates on rising edge.
REQ-003 Rst  in  1  asynchronous, active-high reset.
REQ-004 dec_valid  in  1  decode-stage instruction valid.
REQ-005 dec_jal / dec_jalr / dec_branch  in  1 each  instruction class, one-hot or all zero.
REQ-006 dec_comp  in  1  instruction is compressed (16-bit).
REQ-007 dec_pc  in  32  PC of decode instruction.
REQ-008 branoff  in  32  offset-generator output: PC-relative offset for JAL/branch, absolute target for JALR.
REQ-009 br_taken  in  1  branch compare result for dec_branch.
REQ-010 rd_link / rs1_link  in  1 each  rd / rs1 is x1 or x5.
REQ-011 fetch_ready  in  1  fetch accepts redirect this cycle.
REQ-012 redirect_valid  out  1  redirect request to fetch.
REQ-013 redirect_pc  out  32  redirect target.
REQ-014 flush  out  1  one-cycle pipeline flush pulse.
REQ-015 stall_dec  out  1  hold decode stage.
REQ-016 redirect_cnt  out  32  count of accepted redirects.
REQ-017 ras_valid  out  1  ras_top holds a valid prediction.
REQ-018 ras_top  out  32  predicted return address.

Function
REQ-019 FSM states IDLE, REQ, FLUSH; redirect_valid=1 only in REQ; flush=1 only in FLUSH; stall_dec=1 in REQ and FLUSH.
REQ-020 IDLE: on dec_valid & (dec_jal | dec_jalr | dec_branch & br_taken), capture target and go to REQ next cycle; otherwise stay in IDLE.
REQ-021 Target for JAL/branch = dec_pc + branoff, modulo 2^32; for JALR = branoff with bit 0 cleared.
REQ-022 Not-taken branch and non-control instructions cause no state change and no outputs.
REQ-023 REQ: redirect_pc held stable; on fetch_ready go to FLUSH, else stay in REQ indefinitely.
REQ-024 FLUSH lasts exactly one cycle, then IDLE; decode inputs ignored in REQ and FLUSH.
REQ-025 Latency: qualifying decode in cycle N gives redirect_valid in N+1; fetch_ready in N+1 gives flush in N+2 and IDLE in N+3.
REQ-026 redirect_cnt increments on each REQ->FLUSH transition and saturates at 0xFFFFFFFF.
REQ-027 Link address = dec_pc + 2 if dec_comp, else dec_pc + 4.

Reset
REQ-028 Rst forces IDLE; redirect_valid, flush, stall_dec, ras_valid = 0; redirect_pc, redirect_cnt, ras_top = 0; RAS emptied.
REQ-029 Rst asserted in REQ or FLUSH aborts the redirect immediately with no flush pulse and no count increment.

Configuration
REQ-030 Macro BRANCH_RAS_EN enables the return-address stack; without it ras_valid and ras_top are tied to 0 and no RAS storage exists.
REQ-031 With RAS: push link address on accepted JAL/JALR with rd_link; pop on JALR with rs1_link & !rd_link; pop then push (replace top) on JALR with rd_link & rs1_link.
REQ-032 RAS push when full overwrites the oldest entry (circular); pop when empty leaves it empty; ras_valid = occupancy != 0.
REQ-033 RAS updates only on the IDLE cycle that starts a redirect.

Structure
REQ-034 Package branch_ctrl_pkg holds the FSM state enum and the RAS_DEPTH default constant.
REQ-035 The RAS is a sub-module branch_ras (push, pop, data in, top, valid), instantiated only under BRANCH_RAS_EN.

Verification
REQ-036 JAL, dec_pc=0x100, branoff=0x20, fetch_ready=1 -> redirect_pc=0x120 in N+1, flush in N+2, redirect_cnt=1.
REQ-037 Branch, br_taken=0 -> no redirect_valid or stall; br_taken=1, branoff=0xFFFFFFF0, dec_pc=0x10 -> redirect_pc=0x0.
REQ-038 JALR, branoff=0x2001 -> redirect_pc=0x2000; fetch_ready low 3 cycles -> redirect_valid and stall_dec held 3 cycles, pc stable.
REQ-039 Rst pulse while in REQ -> IDLE next edge, no flush, redirect_cnt unchanged.
REQ-040 BRANCH_RAS_EN, RAS_DEPTH=4: five JAL rd_link at pc 0x0,0x10,0x20,0x30,0x40 (dec_comp=0) -> ras_top=0x44; four pops -> 0x34,0x24,0x14 then ras_valid=0.
REQ-041 Compressed JAL rd_link, dec_pc=0x200 -> ras_top=0x202 with RAS; without macro ras_valid=0.
